// File: rtl/cellrv32_clkgen_pkg.sv
// Shared clock-prescaler constants for the IO subsystem.
// Peripherals select prescaler ticks by index; the index-to-divider-bit
// mapping lives only here.
package cellrv32_clkgen_pkg;

    // number of tick strobes delivered to each requester
    localparam int clkgen_width_c = 8;

    // tick indices as seen on a peripheral's clkgen_i[7:0]
    localparam int clk_div2_c    = 0;
    localparam int clk_div4_c    = 1;
    localparam int clk_div8_c    = 2;
    localparam int clk_div64_c   = 3;
    localparam int clk_div128_c  = 4;
    localparam int clk_div1024_c = 5;
    localparam int clk_div2048_c = 6;
    localparam int clk_div4096_c = 7;

    // divider bit whose rising edge produces tick k (division = 2^(bit+1))
    localparam int clkgen_bit_c [clkgen_width_c] = '{0, 1, 2, 5, 6, 9, 10, 11};

endpackage

// File: rtl/cellrv32_clkgen.sv
// Shared prescaler tick generator. One free-running 12-bit divider runs
// while any peripheral requests it; each requester receives single-cycle
// tick strobes, gated by its own registered request.
module cellrv32_clkgen
    import cellrv32_clkgen_pkg::*;
#(
    parameter int NUM_REQ = 4  // legal range 1..16
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [NUM_REQ-1:0]                  en_i,
    output logic [NUM_REQ*clkgen_width_c-1:0]   clkgen_o,
    output logic                                active_o
);

    logic                      en_q;
    logic [NUM_REQ-1:0]        req_q;
    logic [11:0]               cnt;
    logic [clkgen_width_c-1:0] tap;    // divider bits feeding the ticks
    logic [clkgen_width_c-1:0] tap_d;  // same bits, one cycle delayed
    logic [clkgen_width_c-1:0] rise;

    // register the requests so no output depends combinationally on en_i
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q  <= 1'b0;
            req_q <= '0;
        end else begin
            en_q  <= |en_i;
            req_q <= en_i;
        end
    end

    // divider: counts while enabled, restarts from phase 0 after a full stop.
    // Only the tapped bits need a delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt   <= '0;
            tap_d <= '0;
        end else if (en_q) begin
            cnt   <= cnt + 12'd1;
            tap_d <= tap;
        end else begin
            cnt   <= '0;
            tap_d <= '0;
        end
    end

    for (genvar k = 0; k < clkgen_width_c; k++) begin : g_tap
        assign tap[k] = cnt[clkgen_bit_c[k]];
    end

    // rising edge of each tapped bit; the 4095->0 wrap is a falling edge of
    // bit 11, so no spurious tick appears there
    assign rise = tap & ~tap_d;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        logic [clkgen_width_c-1:0] tick_q;

        // per-requester gating: an idle peripheral never sees strobes
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                tick_q <= '0;
            end else if (en_q && req_q[r]) begin
                tick_q <= rise;
            end else begin
                tick_q <= '0;
            end
        end

        assign clkgen_o[r*clkgen_width_c +: clkgen_width_c] = tick_q;
    end

    assign active_o = en_q;

endmodule

// File: tb/tb_cellrv32_clkgen.sv
// Self-checking bench for cellrv32_clkgen.
// Reference model: after the divider starts at edge S (first edge sampling
// any request), the tick with division d fires on the output after edge n
// when c = n-1-S satisfies c >= 1 and c mod d == d/2, gated by the
// registered enable and the requester's registered request.
module tb_cellrv32_clkgen;

    localparam int NUM_REQ = 4;
    localparam int W       = NUM_REQ * 8;

    logic               clk_i;
    logic               rstn_i;
    logic [NUM_REQ-1:0] en_i;
    logic [W-1:0]       clkgen_o;
    logic               active_o;

    cellrv32_clkgen #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (en_i),
        .clkgen_o (clkgen_o),
        .active_o (active_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // tick divisions by index
    int div_tab [8] = '{2, 4, 8, 64, 128, 1024, 2048, 4096};

    int n_vec = 0;
    int n_bad = 0;

    // model state
    int                 edge_n  = 0;
    bit                 m_en    = 1'b0;
    logic [NUM_REQ-1:0] m_req   = '0;
    int                 m_start = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    function automatic bit tick_due(int c, int d);
        return (c >= 1) && ((c % d) == (d / 2));
    endfunction

    function automatic logic [W-1:0] model_ticks(int n);
        logic [W-1:0] v;
        v = '0;
        if (m_en) begin
            for (int r = 0; r < NUM_REQ; r++)
                for (int k = 0; k < 8; k++)
                    if (m_req[r] && tick_due(n - 1 - m_start, div_tab[k]))
                        v[r*8 + k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_en    = 1'b0;
        m_req   = '0;
        m_start = 0;
    endtask

    // apply one request pattern for one clock edge and check all outputs
    task automatic step(input logic [NUM_REQ-1:0] en);
        logic [W-1:0] expv;
        logic [127:0] obs_w;
        logic [127:0] exp_w;
        en_i = en;
        @(posedge clk_i);
        edge_n++;
        expv = model_ticks(edge_n);
        if (!m_en && (|en)) m_start = edge_n;
        m_en  = |en;
        m_req = en;
        #1;
        obs_w = '0;
        exp_w = '0;
        obs_w[W-1:0] = clkgen_o;
        exp_w[W-1:0] = expv;
        chk("clkgen", obs_w, exp_w);
        chk("active", {127'b0, active_o}, {127'b0, m_en});
    endtask

    initial begin
        int last_hi  [8];
        int first_hi [8];
        int e1;
        logic [NUM_REQ-1:0] ren;
        int hold;
        logic [127:0] obs_w;

        rstn_i = 1'b0;
        en_i   = '0;
        model_reset();

        // reset state
        #12;
        obs_w = '0;
        obs_w[W-1:0] = clkgen_o;
        chk("rst_clkgen", obs_w, 128'd0);
        chk("rst_active", {127'b0, active_o}, 128'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        step('0);
        step('0);

        // cold start with requester 0, long enough to cross the 4095->0 wrap
        for (int k = 0; k < 8; k++) begin
            last_hi[k]  = -1;
            first_hi[k] = -1;
        end
        e1 = edge_n + 1;
        for (int i = 0; i < 10000; i++) begin
            step(4'b0001);
            for (int k = 0; k < 8; k++) begin
                if (clkgen_o[k]) begin
                    if (first_hi[k] < 0)
                        first_hi[k] = edge_n;
                    else
                        chk($sformatf("period_div%0d", div_tab[k]),
                            128'(edge_n - last_hi[k]), 128'(div_tab[k]));
                    last_hi[k] = edge_n;
                end
            end
        end
        chk("first_div2",    128'(first_hi[0]), 128'(e1 + 2));
        chk("first_div4",    128'(first_hi[1]), 128'(e1 + 3));
        chk("first_div4096", 128'(first_hi[7]), 128'(e1 + 2049));

        // late joiner, then partial drop
        for (int i = 0; i < 100; i++) step(4'b0001);
        for (int i = 0; i < 300; i++) step(4'b0011);
        for (int i = 0; i < 300; i++) step(4'b0001);

        // full stop and re-enable
        for (int i = 0; i < 20; i++) step(4'b0000);
        for (int i = 0; i < 1500; i++) step(4'b0001);

        // asynchronous reset mid-count: outputs clear without a clock edge
        #2;
        rstn_i = 1'b0;
        #1;
        obs_w = '0;
        obs_w[W-1:0] = clkgen_o;
        chk("async_rst_clkgen", obs_w, 128'd0);
        chk("async_rst_active", {127'b0, active_o}, 128'd0);
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 2200; i++) step(4'b0001);

        // randomized request patterns
        for (int s = 0; s < 40; s++) begin
            ren  = NUM_REQ'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 600));
            for (int i = 0; i < hold; i++) step(ren);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cellrv32_clkgen.md
# cellrv32_clkgen

Shared clock-prescaler tick generator for the IO subsystem: the producer side of the `clkgen_en` / `clkgen[7:0]` interface consumed by the timer, UART, SPI and similar peripherals. Each peripheral requests ticks by raising its enable line. The block runs one free-running 12-bit divider while any request is active. It returns eight single-cycle tick strobes per requester, at fixed divisions of the system clock. Ticks are gated per requester, so an idle peripheral never sees strobes.

## Interface
- `NUM_REQ`, default 4 — number of requesting peripherals; legal range 1..16.
- `clk_i`  in  1  global clock line; all logic on the rising edge.
- `rstn_i`  in  1  global reset line; asynchronous, active-low.
- `en_i`  in  NUM_REQ  per-requester clock-generator enable; bit r driven by peripheral r's `clkgen_en_o`.
- `clkgen_o`  out  NUM_REQ*8  tick strobes; bits [8r+7:8r] go to peripheral r's `clkgen_i[7:0]`.
- `active_o`  out  1  divider running (registered OR of `en_i`).

## Operation
- Tick index k → division: 0:/2, 1:/4, 2:/8, 3:/64, 4:/128, 5:/1024, 6:/2048, 7:/4096.
- Tick index k → divider bit b(k): 0, 1, 2, 5, 6, 9, 10, 11.
- `en_q` = registered OR-reduction of `en_i`; `req_q` = registered copy of `en_i`.
- `cnt[11:0]` and its one-cycle delayed copy `cnt_d[11:0]`:
  - `en_q`=1: `cnt` ← `cnt`+1, `cnt_d` ← `cnt`.
  - `en_q`=0: both are cleared to 0.
- Rise vector: `rise[k]` = `cnt[b(k)]` & ~`cnt_d[b(k)]` (rising edge of the divider bit).
- Output register: `clkgen_o[8r+k]` ← `en_q` & `req_q[r]` & `rise[k]`.
- `active_o` = `en_q`.
- All requesters share one divider phase. A requester that enables late sees ticks aligned to the already-running count, not to its own enable.
- 12-bit wrap 4095→0: bit 11 falls, so no tick is generated. Lower bits behave normally. Periods stay exact across the wrap.

## Timing
- Reset: `cnt`, `cnt_d`, `en_q`, `req_q` = 0; `clkgen_o` = all 0; `active_o` = 0.
- All outputs are registered; no combinational path from `en_i` to any output.
- Cold start: `en_i` goes 0→1 (all bits previously 0), sampled at edge E1.
  - `active_o`=1 after E1.
  - `cnt`=1 after E2.
  - Tick k first asserts after edge E(2+2^b(k)), e.g. /2 after E3, /4 after E4, /4096 after E2050.
  - Each tick then repeats every 2^(b(k)+1) cycles and is high for exactly one cycle.
- Last request drops (sampled at edge D1):
  - `en_q`=0 after D1.
  - `cnt` and `cnt_d` cleared at D2.
  - `clkgen_o` is all 0 from D2 onward. A tick may still appear in the cycle after D1 for requesters whose `req_q` was still 1.
- Single requester drops while others stay active: its strobes stop one cycle after its `req_q` clears. The divider and other requesters are unaffected.
- Re-enable after full stop: the phase restarts from 0 with cold-start latency.
- Reset asserted mid-count: all state clears immediately (asynchronous). Operation resumes with cold-start latency on the first edge after release.

## Structure
- Shared package constants:
  - `clkgen_width_c` = 8.
  - Tick index constants `clk_div2_c`..`clk_div4096_c` (0..7).
  - Constant array `clkgen_bit_c` mapping tick index → divider bit.
- `index_size_f` is not needed.
- The GPTMR and other peripherals select ticks by index through these constants, so the division mapping lives only in the package.
- Single flat module; no sub-module. The per-requester gating is a generate loop.

## Test plan
- **Cold start, NUM_REQ=4:** `en_i`=4'b0001 held.
  - `active_o`=1 after 1 edge.
  - Bit 0 first high 3 cycles after the enable edge, then every 2 cycles.
  - Bit 7 first high after 2050 edges, then every 4096 cycles.
  - `clkgen_o[31:8]` stays 0.
- **Late joiner:** `en_i`=0001, then after 100 cycles 0011.
  - Requester 1's ticks are cycle-aligned with requester 0's.
  - Requester 1 gets no ticks before `req_q[1]`=1.
- **Partial drop:** `en_i` 0011 → 0001.
  - Requester 1 strobes stop within 2 cycles.
  - Requester 0's /64 period remains exactly 64.
  - `active_o` stays 1.
- **Full stop:** `en_i` → 0.
  - `active_o`=0 after 1 edge; `clkgen_o`=0 from the 2nd edge.
  - Re-enable gives first /2 tick 3 cycles later again.
- **Wrap:** run 10000 cycles.
  - Measured periods are exactly 2, 4, 8, 64, 128, 1024, 2048, 4096 across the 4095→0 wrap.
  - Never two-cycle-wide pulses.
- **Async reset mid-count:** assert `rstn_i`=0 at cycle 1500.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release with `en_i` held, cold-start latencies repeat.
